// File: rtl/rv_sb_pkg.sv
// Shared definitions for the register scoreboard: latency encoding,
// per-register entry layout and the write-after-write ordering rule.
package rv_sb_pkg;

  localparam int SB_LAT_W = 4;
  // issue_lat value that marks a variable-latency op
  localparam logic [SB_LAT_W-1:0] LAT_VAR = '0;

  typedef struct packed {
    logic                busy;
    logic                is_var;
    logic [SB_LAT_W-1:0] cnt;
  } sb_entry_t;

  // A new write to a busy register must wait if the old result would land
  // after it (variable op, or a longer remaining countdown), unless the
  // variable op is completing this very cycle.
  function automatic logic waw_conflict(input logic busy, input logic is_var,
                                        input logic cnt_gt_lat, input logic done_hit);
    return busy & (is_var | cnt_gt_lat) & ~(is_var & done_hit);
  endfunction

endpackage

// File: rtl/rv_scoreboard_sb_entry.sv
// One architectural register's pending-write tracker: install on accept,
// count down fixed-latency results, clear variable ones on completion.
module sb_entry
  import rv_sb_pkg::*;
#(
  parameter int LAT_W = SB_LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_acc,
  input  logic [LAT_W-1:0] i_lat,
  input  logic             i_done,
  output logic             o_busy,
  output logic             o_var,
  output logic [LAT_W-1:0] o_cnt
);

  logic             r_busy;
  logic             r_var;
  logic [LAT_W-1:0] r_cnt;

  // Accept overrides both completion and countdown on the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_var  <= 1'b0;
      r_cnt  <= '0;
    end else if (i_acc) begin
      r_busy <= 1'b1;
      r_cnt  <= i_lat;
      r_var  <= (i_lat == LAT_W'(LAT_VAR));
    end else if (i_done && r_busy && r_var) begin
      r_busy <= 1'b0;
      r_var  <= 1'b0;
    end else if (r_busy && !r_var) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == LAT_W'(1)) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_var  = r_var;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/rv_scoreboard.sv
// Decode-stage register scoreboard: per-register pending-write tracking,
// RAW/WAW/structural issue stall, outstanding variable-op flag, error flag.
module rv_scoreboard
  import rv_sb_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int IDX_W = 5,
  parameter int LAT_W = SB_LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [IDX_W-1:0] issue_rs1,
  input  logic [IDX_W-1:0] issue_rs2,
  input  logic             issue_rs1_used,
  input  logic             issue_rs2_used,
  input  logic             issue_wen,
  input  logic [IDX_W-1:0] issue_rd,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             done_valid,
  input  logic [IDX_W-1:0] done_rd,
  output logic             stall,
  output logic             issue_fire,
  output logic [NREG-1:0]  busy_vec,
  output logic             var_pending,
  output logic             err
);

  logic [NREG-1:0]            w_busy;
  logic [NREG-1:0]            w_var;
  logic [NREG-1:0][LAT_W-1:0] w_cnt;
  logic r_var_pending, r_err;
  logic w_accept, w_lat_var, w_done_ok;
  logic w_hit1, w_hit2, w_raw, w_waw, w_struct;

  // x0 is hardwired free
  assign w_busy[0] = 1'b0;
  assign w_var[0]  = 1'b0;
  assign w_cnt[0]  = '0;

  generate
    for (genvar g = 1; g < NREG; g++) begin : g_ent
      sb_entry #(.LAT_W(LAT_W)) u_ent (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_acc  (w_accept && (issue_rd == IDX_W'(g))),
        .i_lat  (issue_lat),
        .i_done (done_valid && (done_rd == IDX_W'(g))),
        .o_busy (w_busy[g]),
        .o_var  (w_var[g]),
        .o_cnt  (w_cnt[g])
      );
    end
  endgenerate

  assign w_lat_var = (issue_lat == LAT_W'(LAT_VAR));
  assign w_done_ok = done_valid & w_busy[done_rd] & w_var[done_rd];

  // A completing variable op is forwarded in the same cycle, so it no longer hits
  assign w_hit1 = (issue_rs1 != '0) & w_busy[issue_rs1]
                & ~(w_var[issue_rs1] & done_valid & (done_rd == issue_rs1));
  assign w_hit2 = (issue_rs2 != '0) & w_busy[issue_rs2]
                & ~(w_var[issue_rs2] & done_valid & (done_rd == issue_rs2));
  assign w_raw  = (issue_rs1_used & w_hit1) | (issue_rs2_used & w_hit2);
  assign w_waw  = issue_wen & (issue_rd != '0)
                & waw_conflict(w_busy[issue_rd], w_var[issue_rd],
                               w_cnt[issue_rd] > issue_lat,
                               done_valid & (done_rd == issue_rd));
  // Only one variable-latency op may be outstanding at a time
  assign w_struct = issue_wen & w_lat_var & r_var_pending & ~done_valid;

  assign stall      = issue_valid & (w_raw | w_waw | w_struct);
  assign issue_fire = issue_valid & ~stall;
  assign w_accept   = issue_fire & issue_wen & (issue_rd != '0);

  // Outstanding variable op: a new one installed alongside a completion stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_var_pending <= 1'b0;
    else if (w_accept && w_lat_var) r_var_pending <= 1'b1;
    else if (w_done_ok)             r_var_pending <= 1'b0;
  end

  // Sticky flag for a completion pulse with no matching variable entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_err <= 1'b0;
    else if (done_valid && !w_done_ok)  r_err <= 1'b1;
  end

  assign busy_vec    = w_busy;
  assign var_pending = r_var_pending;
  assign err         = r_err;

endmodule

// File: tb/tb_rv_scoreboard.sv
// Directed bench for rv_scoreboard with a ready-time reference model.
module tb_rv_scoreboard;
  localparam int NREG = 32, IDX_W = 5, LAT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic issue_valid, issue_rs1_used, issue_rs2_used, issue_wen, done_valid;
  logic [IDX_W-1:0] issue_rs1, issue_rs2, issue_rd, done_rd;
  logic [LAT_W-1:0] issue_lat;
  logic stall, issue_fire, var_pending, err;
  logic [NREG-1:0] busy_vec;

  int checks = 0, errors = 0;

  // Model: a fixed write is pending while now < rdy[r]; a variable one until done
  int rdy [NREG];
  bit isv [NREG];
  bit m_vp, m_err;
  int now = 0;

  rv_scoreboard #(.NREG(NREG), .IDX_W(IDX_W), .LAT_W(LAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_wen(issue_wen), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .done_valid(done_valid), .done_rd(done_rd), .stall(stall),
    .issue_fire(issue_fire), .busy_vec(busy_vec),
    .var_pending(var_pending), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit m_busy(input int r);
    return isv[r] || (rdy[r] > now);
  endfunction

  function automatic bit m_hit(input logic [IDX_W-1:0] s);
    return (s != 0) && m_busy(int'(s)) && !(isv[s] && done_valid && done_rd == s);
  endfunction

  function automatic bit m_stall();
    bit raw, waw, st;
    raw = (issue_rs1_used && m_hit(issue_rs1)) || (issue_rs2_used && m_hit(issue_rs2));
    waw = issue_wen && issue_rd != 0 && m_busy(int'(issue_rd))
          && (isv[issue_rd] || (rdy[issue_rd] - now) > int'(issue_lat))
          && !(isv[issue_rd] && done_valid && done_rd == issue_rd);
    st  = issue_wen && issue_lat == 0 && m_vp && !done_valid;
    return issue_valid && (raw || waw || st);
  endfunction

  // Compare every cycle at the falling edge, then advance the model one edge
  initial begin
    bit es;
    logic [NREG-1:0] eb;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int r = 0; r < NREG; r++) begin rdy[r] = 0; isv[r] = 0; end
        m_vp = 0; m_err = 0;
        chk("m_rst_stall", 64'(stall), 64'(0));
        chk("m_rst_fire", 64'(issue_fire), 64'(issue_valid));
        chk("m_rst_busy", 64'(busy_vec), 64'(0));
        chk("m_rst_vp", 64'(var_pending), 64'(0));
        chk("m_rst_err", 64'(err), 64'(0));
      end else begin
        es = m_stall();
        for (int r = 0; r < NREG; r++) eb[r] = (r != 0) && m_busy(r);
        chk("m_stall", 64'(stall), 64'(es));
        chk("m_fire", 64'(issue_fire), 64'(issue_valid && !es));
        chk("m_busy_vec", 64'(busy_vec), 64'(eb));
        chk("m_var_pending", 64'(var_pending), 64'(m_vp));
        chk("m_err", 64'(err), 64'(m_err));
        if (done_valid) begin
          if (isv[done_rd]) begin isv[done_rd] = 0; m_vp = 0; end
          else m_err = 1;
        end
        if (issue_valid && !es && issue_wen && issue_rd != 0) begin
          if (issue_lat == 0) begin isv[issue_rd] = 1; rdy[issue_rd] = 0; m_vp = 1; end
          else begin isv[issue_rd] = 0; rdy[issue_rd] = now + 1 + int'(issue_lat); end
        end
        now++;
      end
    end
  end

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rs1_used = 0;
    issue_rs2_used = 0; issue_wen = 0; issue_rd = 0; issue_lat = 0;
    done_valid = 0; done_rd = 0;
  endtask

  task automatic iss(input logic [IDX_W-1:0] rd, input logic [LAT_W-1:0] lat);
    idle();
    issue_valid = 1; issue_wen = 1; issue_rd = rd; issue_lat = lat;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1;
    #1 rst_n = 0;
    #1;
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_fire", 64'(issue_fire), 64'(1));
    chk("rst_busy", 64'(busy_vec), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    tick(); rst_n = 1; idle();
    tick();

    // fixed latency 3 on x5, dependent rs1=5 every cycle
    iss(5, 3); tick();
    idle(); issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fix_stall", 64'(stall), 64'(k < 3));
      chk("fix_fire", 64'(issue_fire), 64'(k == 3));
      chk("fix_busy5", 64'(busy_vec[5]), 64'(k < 3));
      tick();
    end
    idle();

    // variable latency on x7, done bypass
    iss(7, 0); tick();
    idle(); issue_valid = 1; issue_rs2 = 7; issue_rs2_used = 1;
    for (int k = 0; k < 10; k++) begin
      #1 chk("var_stall", 64'(stall), 64'(1));
      tick();
    end
    done_valid = 1; done_rd = 7;
    #1;
    chk("var_bypass_stall", 64'(stall), 64'(0));
    chk("var_bypass_fire", 64'(issue_fire), 64'(1));
    tick(); idle();
    #1;
    chk("var_vp_drop", 64'(var_pending), 64'(0));
    chk("var_busy7", 64'(busy_vec[7]), 64'(0));

    // structural: second variable op waits for a completion
    iss(10, 0); tick();
    iss(11, 0);
    #1 chk("struct_stall", 64'(stall), 64'(1));
    tick();
    #1 chk("struct_stall2", 64'(stall), 64'(1));
    done_valid = 1; done_rd = 10;
    #1 chk("struct_release", 64'(stall), 64'(0));
    tick(); idle();
    #1;
    chk("struct_vp", 64'(var_pending), 64'(1));
    chk("struct_busy11", 64'(busy_vec[11]), 64'(1));
    chk("struct_busy10", 64'(busy_vec[10]), 64'(0));
    done_valid = 1; done_rd = 11;
    tick(); idle();
    #1 chk("struct_vp_clr", 64'(var_pending), 64'(0));

    // WAW: x3 lat 4 then x3 lat 1 waits until remaining count <= 1
    iss(3, 4); tick();
    iss(3, 1);
    for (int k = 0; k < 4; k++) begin
      #1 chk("waw_stall", 64'(stall), 64'(k < 3));
      tick();
    end
    idle();
    #1 chk("waw_new_busy", 64'(busy_vec[3]), 64'(1));
    tick();
    #1 chk("waw_new_clr", 64'(busy_vec[3]), 64'(0));

    // same-cycle completion and re-accept on x9
    iss(9, 0); tick();
    iss(9, 2); done_valid = 1; done_rd = 9;
    #1 chk("same_stall", 64'(stall), 64'(0));
    tick(); idle();
    #1;
    chk("same_busy9_a", 64'(busy_vec[9]), 64'(1));
    chk("same_vp", 64'(var_pending), 64'(0));
    tick();
    #1 chk("same_busy9_b", 64'(busy_vec[9]), 64'(1));
    tick();
    #1 chk("same_busy9_c", 64'(busy_vec[9]), 64'(0));

    // stray completion sets err
    done_valid = 1; done_rd = 4;
    #1 chk("err_before", 64'(err), 64'(0));
    tick(); idle();
    #1;
    chk("err_set", 64'(err), 64'(1));
    chk("err_busy", 64'(busy_vec), 64'(0));

    // x0 is never tracked
    iss(0, 2); issue_rs1 = 0; issue_rs1_used = 1;
    #1 chk("x0_stall", 64'(stall), 64'(0));
    tick(); idle();
    #1 chk("x0_busy", 64'(busy_vec), 64'(0));

    // reset mid-operation
    iss(8, 0); tick();
    iss(6, 5); tick(); idle();
    #1;
    chk("pre_rst_busy6", 64'(busy_vec[6]), 64'(1));
    chk("pre_rst_vp", 64'(var_pending), 64'(1));
    #1 rst_n = 0;
    #1;
    chk("mid_rst_busy", 64'(busy_vec), 64'(0));
    chk("mid_rst_vp", 64'(var_pending), 64'(0));
    chk("mid_rst_err", 64'(err), 64'(0));
    @(posedge clk); #1 rst_n = 1;
    issue_valid = 1; issue_rs1 = 6; issue_rs1_used = 1; issue_rs2 = 8; issue_rs2_used = 1;
    #1;
    chk("post_rst_stall", 64'(stall), 64'(0));
    chk("post_rst_fire", 64'(issue_fire), 64'(1));
    tick(); idle(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
